// File: rtl/fb_scanout.sv
`default_nettype none
// ============================================================================
// fb_scanout : row fetch into ping-pong line buffer, 2x2 replay, frame swap
// Revision  : 1.0
// ============================================================================
module fb_scanout #(
  parameter int          FB_W         = 320,
  parameter int          FB_H         = 240,
  parameter logic [17:0] FRAME1_BASE  = 18'h20000,
  parameter int          READ_LATENCY = 2,
  parameter int          V_LAST       = 524
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pix_ce,
  input  logic [9:0]  drawX,
  input  logic [9:0]  drawY,
  input  logic        hblank,
  input  logic        vblank,
  input  logic        swap_req,
  output logic [17:0] fb_addrb,
  output logic        fb_enb,
  input  logic [7:0]  fb_doutb,
  output logic [7:0]  pixel_idx,
  output logic        front_sel,
  output logic        swap_ack,
  output logic        busy,
  output logic        underrun
);

  localparam int ADDR_W = 18;
  localparam int COL_W  = $clog2(FB_W);
  localparam int ROW_W  = $clog2(FB_H);
  localparam int LAT_W  = $clog2(READ_LATENCY + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [LAT_W-1:0]   drain_q, drain_d;
  logic               hblank_q, hblank_d;
  logic               vblank_q, vblank_d;
  logic               pending_q, pending_d;
  logic               front_sel_q, front_sel_d;
  logic               swap_ack_q, swap_ack_d;
  logic               underrun_q, underrun_d;
  logic [7:0]         pixel_idx_q, pixel_idx_d;

  logic [READ_LATENCY-1:0] vld_pipe_q, vld_pipe_d;
  logic [READ_LATENCY-1:0] bank_pipe_q, bank_pipe_d;
  logic [COL_W-1:0]        col_pipe_q [READ_LATENCY];
  logic [COL_W-1:0]        col_pipe_d [READ_LATENCY];

  logic [7:0] linebuf [2][FB_W];

  logic [9:0]        next_y;
  logic              fetch_trig;
  logic              vblank_rise;
  logic [9:0]        px_col;
  logic              px_vis;
  logic [ADDR_W-1:0] row_ext;
  logic [ADDR_W-1:0] row_off;
  logic [ADDR_W-1:0] fetch_addr;

  // Fetch the row shown on the upcoming line pair, only on even target lines.
  always_comb begin
    next_y     = (drawY == 10'(V_LAST)) ? 10'd0 : drawY + 10'd1;
    fetch_trig = hblank && !hblank_q && (next_y < 10'(2 * FB_H)) && !next_y[0];
  end

  assign row_ext = ADDR_W'(row_q);

  generate
    if (FB_W == 320) begin : g_row_off_shift
      assign row_off = (row_ext << 8) + (row_ext << 6);
    end else begin : g_row_off_mul
      assign row_off = row_ext * ADDR_W'(FB_W);
    end
  endgenerate

  assign fetch_addr = (front_sel_q ? FRAME1_BASE : '0) + row_off + ADDR_W'(col_q);

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    drain_d = drain_q;
    unique case (state_q)
      S_IDLE: begin
        if (fetch_trig) begin
          state_d = S_FETCH;
          col_d   = '0;
          row_d   = ROW_W'(next_y >> 1);
        end
      end
      S_FETCH: begin
        if (col_q == COL_W'(FB_W - 1)) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end else begin
          col_d = col_q + COL_W'(1);
        end
      end
      S_DRAIN: begin
        drain_d = drain_q + LAT_W'(1);
        if (drain_q == LAT_W'(READ_LATENCY - 1)) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign fb_enb   = (state_q == S_FETCH);
  assign fb_addrb = fb_enb ? fetch_addr : '0;
  assign busy     = (state_q != S_IDLE);

  // Column/bank tags travel alongside the read so the data lands where it was asked for.
  always_comb begin
    vld_pipe_d[0]  = (state_q == S_FETCH);
    bank_pipe_d[0] = row_q[0];
    col_pipe_d[0]  = col_q;
    for (int i = 1; i < READ_LATENCY; i++) begin
      vld_pipe_d[i]  = vld_pipe_q[i-1];
      bank_pipe_d[i] = bank_pipe_q[i-1];
      col_pipe_d[i]  = col_pipe_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (vld_pipe_q[READ_LATENCY-1]) begin
      linebuf[bank_pipe_q[READ_LATENCY-1]][col_pipe_q[READ_LATENCY-1]] <= fb_doutb;
    end
  end

  always_comb begin
    px_col      = drawX >> 1;
    px_vis      = !hblank && !vblank && (px_col < 10'(FB_W));
    pixel_idx_d = pixel_idx_q;
    if (pix_ce) begin
      pixel_idx_d = px_vis ? linebuf[drawY[1]][px_col[COL_W-1:0]] : 8'd0;
    end
  end

  // A request landing on the vblank edge itself is honoured on that edge.
  always_comb begin
    hblank_d    = hblank;
    vblank_d    = vblank;
    vblank_rise = vblank && !vblank_q;
    front_sel_d = front_sel_q;
    pending_d   = pending_q;
    swap_ack_d  = 1'b0;
    if (vblank_rise && (pending_q || swap_req)) begin
      front_sel_d = !front_sel_q;
      pending_d   = 1'b0;
      swap_ack_d  = 1'b1;
    end else if (swap_req) begin
      pending_d = 1'b1;
    end
    underrun_d = underrun_q || (!hblank && hblank_q && busy);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      drain_q     <= '0;
      hblank_q    <= 1'b0;
      vblank_q    <= 1'b0;
      pending_q   <= 1'b0;
      front_sel_q <= 1'b0;
      swap_ack_q  <= 1'b0;
      underrun_q  <= 1'b0;
      pixel_idx_q <= 8'd0;
      vld_pipe_q  <= '0;
      bank_pipe_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        col_pipe_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      drain_q     <= drain_d;
      hblank_q    <= hblank_d;
      vblank_q    <= vblank_d;
      pending_q   <= pending_d;
      front_sel_q <= front_sel_d;
      swap_ack_q  <= swap_ack_d;
      underrun_q  <= underrun_d;
      pixel_idx_q <= pixel_idx_d;
      vld_pipe_q  <= vld_pipe_d;
      bank_pipe_q <= bank_pipe_d;
      for (int i = 0; i < READ_LATENCY; i++) begin
        col_pipe_q[i] <= col_pipe_d[i];
      end
    end
  end

  assign pixel_idx = pixel_idx_q;
  assign front_sel = front_sel_q;
  assign swap_ack  = swap_ack_q;
  assign underrun  = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_fb_scanout.sv
`default_nettype none
// tb_fb_scanout : directed vectors for fb_scanout with a 2-clk-latency frame-buffer model.
module tb_fb_scanout;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        pix_ce;
  logic [9:0]  drawX;
  logic [9:0]  drawY;
  logic        hblank;
  logic        vblank;
  logic        swap_req;
  logic [17:0] fb_addrb;
  logic        fb_enb;
  logic [7:0]  fb_doutb;
  logic [7:0]  pixel_idx;
  logic        front_sel;
  logic        swap_ack;
  logic        busy;
  logic        underrun;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fb_scanout dut (
    .clk(clk), .reset_n(reset_n), .pix_ce(pix_ce), .drawX(drawX), .drawY(drawY),
    .hblank(hblank), .vblank(vblank), .swap_req(swap_req),
    .fb_addrb(fb_addrb), .fb_enb(fb_enb), .fb_doutb(fb_doutb),
    .pixel_idx(pixel_idx), .front_sel(front_sel), .swap_ack(swap_ack),
    .busy(busy), .underrun(underrun)
  );

  // Frame 0 holds a[7:0]; frame 1 is scrambled so the base address is observable.
  function automatic logic [7:0] fbmem(input logic [17:0] a);
    return a[17] ? (a[7:0] ^ 8'h5A) : a[7:0];
  endfunction

  logic [7:0] rd_d1, rd_d2;
  always @(posedge clk) begin
    rd_d1 <= fb_enb ? fbmem(fb_addrb) : 8'hEE;
    rd_d2 <= rd_d1;
  end
  assign fb_doutb = rd_d2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_line(input logic [9:0] y, input int drop_at,
                            output int n_enb, output int n_busy,
                            output int first, output int last, output int gaps);
    n_enb = 0; n_busy = 0; first = -1; last = -1; gaps = 0;
    drawY  = y;
    hblank = 1'b0;
    step();
    hblank = 1'b1;
    for (int i = 0; i < 700; i++) begin
      if (i == drop_at) hblank = 1'b0;
      step();
      if (fb_enb) begin
        if (n_enb == 0) first = int'(fb_addrb);
        else if (int'(fb_addrb) != last + 1) gaps++;
        last = int'(fb_addrb);
        n_enb++;
      end
      if (busy) n_busy++;
    end
    hblank = 1'b0;
  endtask

  task automatic scan(input logic [9:0] x, input logic [9:0] y, input logic hb, input logic vb);
    drawX  = x;
    drawY  = y;
    hblank = hb;
    vblank = vb;
    pix_ce = 1'b1;
    step();
    pix_ce = 1'b0;
  endtask

  typedef struct {
    logic       hb;
    logic       vb;
    logic [9:0] x;
    logic [9:0] y;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [12];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_enb, n_busy, first, last, gaps, cnt;
    logic found;

    vecs[0]  = '{1'b0, 1'b0, 10'd7,   10'd10, 8'h43};
    vecs[1]  = '{1'b0, 1'b0, 10'd0,   10'd10, 8'h40};
    vecs[2]  = '{1'b0, 1'b0, 10'd639, 10'd10, 8'h7F};
    vecs[3]  = '{1'b0, 1'b0, 10'd1,   10'd11, 8'h40};
    vecs[4]  = '{1'b0, 1'b0, 10'd200, 10'd11, 8'hA4};
    vecs[5]  = '{1'b0, 1'b0, 10'd7,   10'd11, 8'h43};
    vecs[6]  = '{1'b0, 1'b0, 10'd0,   10'd12, 8'h80};
    vecs[7]  = '{1'b0, 1'b0, 10'd639, 10'd13, 8'hBF};
    vecs[8]  = '{1'b0, 1'b0, 10'd300, 10'd12, 8'h16};
    vecs[9]  = '{1'b1, 1'b0, 10'd7,   10'd10, 8'h00};
    vecs[10] = '{1'b0, 1'b1, 10'd7,   10'd10, 8'h00};
    vecs[11] = '{1'b0, 1'b0, 10'd6,   10'd13, 8'h83};

    reset_n = 1'b0; pix_ce = 1'b0; drawX = '0; drawY = '0;
    hblank = 1'b0; vblank = 1'b0; swap_req = 1'b0;

    // Reset with random inputs
    for (int i = 0; i < 8; i++) begin
      pix_ce   = 1'($urandom);
      drawX    = 10'($urandom_range(0, 799));
      drawY    = 10'($urandom_range(0, 524));
      hblank   = 1'($urandom);
      vblank   = 1'($urandom);
      swap_req = 1'($urandom);
      step();
      check("reset_outputs",
            32'({pixel_idx, fb_addrb, fb_enb, front_sel, swap_ack, busy, underrun}), 32'd0);
    end
    pix_ce = 1'b0; drawX = '0; drawY = 10'd100; hblank = 1'b0; vblank = 1'b0; swap_req = 1'b0;
    step();
    reset_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (fb_enb || busy) cnt++;
    end
    check("idle_after_reset", 32'(cnt), 32'd0);

    // Row 5 fetched on line 9
    fetch_line(10'd9, 640, n_enb, n_busy, first, last, gaps);
    check("row5_enb_count", 32'(n_enb), 32'd320);
    check("row5_busy_count", 32'(n_busy), 32'd322);
    check("row5_first_addr", 32'(first), 32'd1600);
    check("row5_last_addr", 32'(last), 32'd1919);
    check("row5_addr_gaps", 32'(gaps), 32'd0);
    check("row5_no_underrun", 32'(underrun), 32'd0);

    // Odd target line: no fetch
    fetch_line(10'd10, 640, n_enb, n_busy, first, last, gaps);
    check("line10_no_enb", 32'(n_enb), 32'd0);
    check("line10_no_busy", 32'(n_busy), 32'd0);

    // Row 6 into the other bank
    fetch_line(10'd11, 640, n_enb, n_busy, first, last, gaps);
    check("row6_enb_count", 32'(n_enb), 32'd320);
    check("row6_first_addr", 32'(first), 32'd1920);

    for (int i = 0; i < 12; i++) begin
      scan(vecs[i].x, vecs[i].y, vecs[i].hb, vecs[i].vb);
      check($sformatf("scan_vec%0d", i), 32'(pixel_idx), 32'(vecs[i].exp));
    end
    hblank = 1'b0; vblank = 1'b0;
    step();

    // pixel_idx holds between strobes
    scan(10'd7, 10'd10, 1'b0, 1'b0);
    drawX = 10'd0;
    step();
    step();
    check("pixel_hold", 32'(pixel_idx), 32'h43);

    // Swap deferred to vblank rise; two requests give one swap
    swap_req = 1'b1; step(); swap_req = 1'b0;
    step(); step(); step();
    check("swap_deferred_sel", 32'(front_sel), 32'd0);
    check("swap_deferred_ack", 32'(swap_ack), 32'd0);
    swap_req = 1'b1; step(); swap_req = 1'b0; step();
    vblank = 1'b1; drawY = 10'd480;
    step();
    check("swap_sel_on_vblank", 32'(front_sel), 32'd1);
    check("swap_ack_pulse", 32'(swap_ack), 32'd1);
    step();
    check("swap_ack_one_clk", 32'(swap_ack), 32'd0);
    vblank = 1'b0; step();
    vblank = 1'b1; step();
    check("single_swap_sel", 32'(front_sel), 32'd1);
    check("single_swap_ack", 32'(swap_ack), 32'd0);

    // Row 0 of frame 1 fetched on line 524
    fetch_line(10'd524, 640, n_enb, n_busy, first, last, gaps);
    check("frame1_first_addr", 32'(first), 32'h20000);
    check("frame1_last_addr", 32'(last), 32'h2013F);
    check("frame1_enb_count", 32'(n_enb), 32'd320);
    scan(10'd2, 10'd0, 1'b0, 1'b0);
    check("frame1_pix_x2", 32'(pixel_idx), 32'h5B);
    scan(10'd639, 10'd1, 1'b0, 1'b0);
    check("frame1_pix_x639", 32'(pixel_idx), 32'h65);

    // swap_req coincident with the vblank edge
    step();
    swap_req = 1'b1; vblank = 1'b1;
    step();
    swap_req = 1'b0;
    check("sameclk_swap_sel", 32'(front_sel), 32'd0);
    check("sameclk_swap_ack", 32'(swap_ack), 32'd1);
    step();
    check("sameclk_ack_clear", 32'(swap_ack), 32'd0);
    vblank = 1'b0;
    step();

    // Underrun: hblank drops 100 clk into the fetch
    check("underrun_clear_before", 32'(underrun), 32'd0);
    fetch_line(10'd13, 100, n_enb, n_busy, first, last, gaps);
    check("underrun_set", 32'(underrun), 32'd1);
    check("underrun_enb_count", 32'(n_enb), 32'd320);
    check("underrun_busy_count", 32'(n_busy), 32'd322);
    check("underrun_first_addr", 32'(first), 32'd2240);
    for (int i = 0; i < 50; i++) step();
    check("underrun_sticky", 32'(underrun), 32'd1);

    // Reset mid-fetch at col 150 of row 8, frame 1
    swap_req = 1'b1; step(); swap_req = 1'b0;
    vblank = 1'b1; step();
    vblank = 1'b0; step();
    check("pre_reset_sel", 32'(front_sel), 32'd1);
    drawY = 10'd15; step();
    hblank = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      step();
      if (fb_enb && fb_addrb == 18'h20000 + 18'd2710) found = 1'b1;
    end
    check("reached_col150", 32'(found), 32'd1);
    reset_n = 1'b0;
    #1;
    check("rst_mid_enb", 32'(fb_enb), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_sel", 32'(front_sel), 32'd0);
    check("rst_mid_addr", 32'(fb_addrb), 32'd0);
    check("rst_mid_underrun", 32'(underrun), 32'd0);
    hblank = 1'b0;
    step(); step();
    reset_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 400; i++) begin
      step();
      if (fb_enb) cnt++;
    end
    check("no_residual_reads", 32'(cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
